goml_ctrl: RTL and testbench

GOML_CTRL -- requirements
Module: goml_ctrl

---
 rtl/goml_ctrl.sv | 151 +++++++++++++++
 tb/tb_goml_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/goml_ctrl.sv
// goML launch/evaluate/replay controller: dual-rail error check with four-phase replay handshake.
// Optional macro GOML_RETRY_LIMIT_EN turns an error after MAX_RETRY replays into a fault.
module goml_ctrl #(
   parameter int MAX_RETRY    = 3,
   parameter int EVAL_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_in,
   output logic       ack_out,
   output logic       go_ml,
   output logic       sample,
   input  logic       err1,
   input  logic       err0,
   output logic       rreq,
   input  logic       reack,
   output logic [3:0] retry_cnt,
   output logic       busy,
   output logic       fatal,
   output logic [2:0] o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LAUNCH     = 3'd1,
      S_SAMPLE     = 3'd2,
      S_EVAL       = 3'd3,
      S_REPLAY     = 3'd4,
      S_REPLAY_RTZ = 3'd5,
      S_DONE       = 3'd6,
      S_FAULT      = 3'd7
   } state_t;

   localparam logic [7:0] LP_TMO_LAST = 8'(EVAL_TIMEOUT - 1);

   if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_max_retry
      $error("goml_ctrl: MAX_RETRY out of range 1..15");
   end
   if (EVAL_TIMEOUT < 2 || EVAL_TIMEOUT > 255) begin : g_bad_timeout
      $error("goml_ctrl: EVAL_TIMEOUT out of range 2..255");
   end

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_tmo;
   logic [7:0] w_tmo_next;
   logic [3:0] r_retry;
   logic [3:0] w_retry_next;
   logic [1:0] w_err;
   logic       r_go_ml, r_sample, r_rreq, r_ack, r_busy, r_fatal;
   logic       w_go_ml, w_sample, w_rreq, w_ack, w_busy, w_fatal;

   assign w_err = {err1, err0};

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (req_in) w_next = S_LAUNCH;
         S_LAUNCH:     w_next = S_SAMPLE;
         S_SAMPLE:     w_next = S_EVAL;
         S_EVAL: begin
            case (w_err)
               2'b01: w_next = S_DONE;
`ifdef GOML_RETRY_LIMIT_EN
               2'b10: w_next = (r_retry == 4'(MAX_RETRY)) ? S_FAULT : S_REPLAY;
`else
               2'b10: w_next = S_REPLAY;
`endif
               2'b11: w_next = S_FAULT;
               default: if (r_tmo == LP_TMO_LAST) w_next = S_FAULT;
            endcase
         end
         S_REPLAY:     if (reack) w_next = S_REPLAY_RTZ;
         S_REPLAY_RTZ: if (!reack) w_next = S_LAUNCH;
         S_DONE:       if (!req_in) w_next = S_IDLE;
         S_FAULT:      w_next = S_FAULT;
         default:      w_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every output is a flop that
   // changes on the same edge as the state it belongs to.
   always_comb begin
      w_go_ml      = 1'b0;
      w_sample     = 1'b0;
      w_rreq       = 1'b0;
      w_ack        = 1'b0;
      w_busy       = 1'b1;
      w_fatal      = 1'b0;
      w_tmo_next   = 8'd0;
      w_retry_next = r_retry;
      case (w_next)
         S_IDLE:   w_busy = 1'b0;
         S_LAUNCH: w_go_ml = 1'b1;
         S_SAMPLE: begin
            w_go_ml  = 1'b1;
            w_sample = 1'b1;
         end
         S_EVAL:   w_go_ml = 1'b1;
         S_REPLAY: w_rreq = 1'b1;
         S_DONE:   w_ack = 1'b1;
         S_FAULT: begin
            w_busy  = 1'b0;
            w_fatal = 1'b1;
         end
         default:  w_busy = 1'b1;
      endcase
      if (r_state == S_EVAL && w_next == S_EVAL) begin
         w_tmo_next = r_tmo + 8'd1;
      end
      if (r_state == S_IDLE && w_next == S_LAUNCH) begin
         w_retry_next = 4'd0;
      end else if (r_state == S_EVAL && w_next == S_REPLAY && r_retry != 4'hF) begin
         w_retry_next = r_retry + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_tmo    <= 8'd0;
         r_retry  <= 4'd0;
         r_go_ml  <= 1'b0;
         r_sample <= 1'b0;
         r_rreq   <= 1'b0;
         r_ack    <= 1'b0;
         r_busy   <= 1'b0;
         r_fatal  <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_tmo    <= w_tmo_next;
         r_retry  <= w_retry_next;
         r_go_ml  <= w_go_ml;
         r_sample <= w_sample;
         r_rreq   <= w_rreq;
         r_ack    <= w_ack;
         r_busy   <= w_busy;
         r_fatal  <= w_fatal;
      end
   end

   assign go_ml       = r_go_ml;
   assign sample      = r_sample;
   assign rreq        = r_rreq;
   assign ack_out     = r_ack;
   assign busy        = r_busy;
   assign fatal       = r_fatal;
   assign retry_cnt   = r_retry;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_goml_ctrl.sv
// Bench for goml_ctrl: builds a per-cycle schedule of inputs and expected outputs from
// transaction plans (attempt outcomes, pending delays, handshake delays), then replays it.
module tb_goml_ctrl;

   localparam int MAX_RETRY    = 3;
   localparam int EVAL_TIMEOUT = 8;

   logic       clk = 1'b0;
   logic       rst, req_in, err1, err0, reack;
   logic       ack_out, go_ml, sample, rreq, busy, fatal;
   logic [3:0] retry_cnt;
   logic [2:0] dbg_state;

   // Inputs per cycle: {rst, req_in, err1, err0, reack}
   logic [4:0] in_q[$];
   // Expected per cycle: {go_ml, sample, rreq, ack_out, busy, fatal, retry_cnt}
   logic [9:0] exp_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cur_retry = 0;

   goml_ctrl #(.MAX_RETRY(MAX_RETRY), .EVAL_TIMEOUT(EVAL_TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_in      (req_in),
      .ack_out     (ack_out),
      .go_ml       (go_ml),
      .sample      (sample),
      .err1        (err1),
      .err0        (err0),
      .rreq        (rreq),
      .reack       (reack),
      .retry_cnt   (retry_cnt),
      .busy        (busy),
      .fatal       (fatal),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b (go,smp,rreq,ack,busy,fatal,retry)", tag, got, exp);
      end
   endtask

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [4:0] mk_in(bit r, bit q, bit e1, bit e0, bit a);
      return {r, q, e1, e0, a};
   endfunction

   function automatic logic [9:0] mk_exp(bit go, bit smp, bit rq, bit ack, bit bsy, bit ftl);
      return {go, smp, rq, ack, bsy, ftl, 4'(cur_retry)};
   endfunction

   task automatic push(input logic [4:0] i, input logic [9:0] e);
      in_q.push_back(i);
      exp_q.push_back(e);
   endtask

   // Faulted: only fatal is high, inputs are irrelevant until a reset cycle.
   task automatic fault_tail();
      repeat ($urandom_range(1, 4)) push(mk_in(0, rb(), rb(), rb(), rb()), mk_exp(0, 0, 0, 0, 0, 1));
      push(mk_in(1, rb(), rb(), rb(), rb()), mk_exp(0, 0, 0, 0, 0, 1));
      cur_retry = 0;
   endtask

   // kind: 0 clean finish, 1 illegal code, 2 eval timeout, 3 reset during the final replay.
   // Attempts before the last one report an error; r1 < 0 means random reack delay.
   task automatic gen_txn(input int n_err, input int kind, input int gap, input int pend_max,
                          input int r1);
      repeat (gap) push(mk_in(0, 0, rb(), rb(), rb()), mk_exp(0, 0, 0, 0, 0, 0));
      push(mk_in(0, 1, rb(), rb(), rb()), mk_exp(0, 0, 0, 0, 0, 0));
      cur_retry = 0;
      for (int a = 0; a <= n_err; a++) begin
         logic [1:0] code;
         bit         tmo;
         int         pend;
         int         d1;
         code = 2'b10;
         tmo  = 1'b0;
         if (a == n_err) begin
            case (kind)
               0: code = 2'b01;
               1: code = 2'b11;
               2: tmo = 1'b1;
               default: code = 2'b10;
            endcase
         end
         pend = tmo ? EVAL_TIMEOUT : int'($urandom_range(0, pend_max));
         push(mk_in(0, rb(), rb(), rb(), rb()), mk_exp(1, 0, 0, 0, 1, 0));
         push(mk_in(0, rb(), rb(), rb(), rb()), mk_exp(1, 1, 0, 0, 1, 0));
         repeat (pend) push(mk_in(0, rb(), 0, 0, rb()), mk_exp(1, 0, 0, 0, 1, 0));
         if (tmo) begin
            fault_tail();
            return;
         end
         push(mk_in(0, rb(), code[1], code[0], rb()), mk_exp(1, 0, 0, 0, 1, 0));
         if (code == 2'b11) begin
            fault_tail();
            return;
         end
         if (code == 2'b01) begin
            repeat ($urandom_range(0, 3)) push(mk_in(0, 1, rb(), rb(), rb()), mk_exp(0, 0, 0, 1, 1, 0));
            push(mk_in(0, 0, rb(), rb(), rb()), mk_exp(0, 0, 0, 1, 1, 0));
            return;
         end
`ifdef GOML_RETRY_LIMIT_EN
         if (cur_retry == MAX_RETRY) begin
            fault_tail();
            return;
         end
`endif
         if (cur_retry < 15) cur_retry++;
         if (kind == 3 && a == n_err) begin
            push(mk_in(1, rb(), rb(), rb(), rb()), mk_exp(0, 0, 1, 0, 1, 0));
            cur_retry = 0;
            return;
         end
         d1 = (r1 < 0) ? int'($urandom_range(0, 3)) : r1;
         repeat (d1) push(mk_in(0, rb(), rb(), rb(), 0), mk_exp(0, 0, 1, 0, 1, 0));
         push(mk_in(0, rb(), rb(), rb(), 1), mk_exp(0, 0, 1, 0, 1, 0));
         repeat ($urandom_range(0, 2)) push(mk_in(0, rb(), rb(), rb(), 1), mk_exp(0, 0, 0, 0, 1, 0));
         push(mk_in(0, rb(), rb(), rb(), 0), mk_exp(0, 0, 0, 0, 1, 0));
      end
   endtask

   initial begin
      int k;
      rst    = 1'b1;
      req_in = 1'b0;
      err1   = 1'b0;
      err0   = 1'b0;
      reack  = 1'b0;

      gen_txn(0, 0, 1, 0, 0);     // clean first attempt, minimum latency
      gen_txn(2, 0, 2, 0, 2);     // two replays, reack after 2 cycles each
      gen_txn(0, 1, 1, 1, -1);    // illegal code
      gen_txn(0, 2, 1, 0, -1);    // pending until timeout
      gen_txn(18, 0, 1, 1, 1);    // persistent errors: retry limit or saturation
      gen_txn(1, 3, 1, 1, -1);    // reset while rreq is high
      gen_txn(0, 0, 0, 0, 0);     // normal transaction right after that reset
      for (int t = 0; t < 24; t++) begin
         int kd;
         kd = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
         gen_txn($urandom_range(0, 4), kd, $urandom_range(0, 3), 3, -1);
      end
      push(mk_in(0, 0, rb(), rb(), rb()), mk_exp(0, 0, 0, 0, 0, 0));

      repeat (2) @(posedge clk);
      k = 0;
      while (in_q.size() > 0) begin
         logic [9:0] e;
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("cycle%0d", k), {go_ml, sample, rreq, ack_out, busy, fatal, retry_cnt}, e);
         {rst, req_in, err1, err0, reack} = in_q.pop_front();
         k++;
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
